// File: rtl/mem_stage_if.sv
// Data-memory read port between the MEM stage (master) and the data memory (slave).
interface mem_stage_if;
    logic        dmem_req;
    logic [31:0] dmem_addr;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (output dmem_req, output dmem_addr, input dmem_ack, input dmem_rdata);
    modport slave  (input dmem_req, input dmem_addr, output dmem_ack, output dmem_rdata);
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: branch resolution, stalling data-memory loads and the MEM/WB register.
// Optional feature MEM_STAGE_MISALIGN_TRAP_EN: misaligned LH/LHU/LW trap instead of accessing memory.
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        memread_MEM,
    input  logic        regwrite_MEM,
    input  logic        j_MEM,
    input  logic        br_MEM,
    input  logic        EQ_MEM,
    input  logic        LT_MEM,
    input  logic        LTU_MEM,
    input  logic [2:0]  funct3_MEM,
    input  logic [4:0]  rd_MEM,
    input  logic [31:0] BTA_MEM,
    input  logic [31:0] ALU_data_MEM,
    mem_stage_if.master dmem,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        stall,
    output logic        regwrite_WB,
    output logic [4:0]  rd_WB,
    output logic [31:0] wb_data_WB
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    ,
    output logic        misalign_WB
`endif
);
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_DONE = 2'd2} state_t;

    state_t      state_r;
    logic [31:0] load_buf_r;
    logic        cond_s;
    logic        misalign_s;
    logic        load_start_s;
    logic        busy_s;

    function automatic logic [31:0] format_load(input logic [2:0] f3, input logic [1:0] a,
                                                input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  format_load = {{24{b[7]}}, b};
            3'b001:  format_load = {{16{h[15]}}, h};
            3'b010:  format_load = w;
            3'b100:  format_load = {24'd0, b};
            3'b101:  format_load = {16'd0, h};
            default: format_load = 32'd0;
        endcase
    endfunction

    // Branch condition select and redirect
    always_comb begin
        case (funct3_MEM)
            3'b000:  cond_s = EQ_MEM;
            3'b001:  cond_s = ~EQ_MEM;
            3'b100:  cond_s = LT_MEM;
            3'b101:  cond_s = ~LT_MEM;
            3'b110:  cond_s = LTU_MEM;
            3'b111:  cond_s = ~LTU_MEM;
            default: cond_s = 1'b0;
        endcase
        redirect    = j_MEM | (br_MEM & cond_s);
        redirect_pc = BTA_MEM;
    end

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    // Misaligned halfword/word loads skip memory and trap in WB
    always_comb begin
        case (funct3_MEM)
            3'b001, 3'b101: misalign_s = memread_MEM & ALU_data_MEM[0];
            3'b010:         misalign_s = memread_MEM & (ALU_data_MEM[1:0] != 2'b00);
            default:        misalign_s = 1'b0;
        endcase
    end
`else
    assign misalign_s = 1'b0;
`endif

    // Request/stall decode; reset forces both low so an in-flight request drops at once
    always_comb begin
        load_start_s = memread_MEM & ~misalign_s;
        if (reset) begin
            busy_s = 1'b0;
        end else if (state_r == ST_WAIT) begin
            busy_s = 1'b1;
        end else if (state_r == ST_IDLE) begin
            busy_s = load_start_s;
        end else begin
            busy_s = 1'b0;
        end
    end

    assign stall          = busy_s;
    assign dmem.dmem_req  = busy_s;
    assign dmem.dmem_addr = {ALU_data_MEM[31:2], 2'b00};

    // Load FSM and read-data buffer; acks are only accepted while waiting
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            load_buf_r <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (load_start_s) begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (dmem.dmem_ack) begin
                        load_buf_r <= dmem.dmem_rdata;
                        state_r    <= ST_DONE;
                    end
                end
                ST_DONE: state_r <= ST_IDLE;
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // MEM/WB register: bubble while stalled, otherwise advance
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regwrite_WB <= 1'b0;
            rd_WB       <= 5'd0;
            wb_data_WB  <= 32'd0;
        end else if (busy_s) begin
            regwrite_WB <= 1'b0;
        end else begin
            regwrite_WB <= regwrite_MEM & ~misalign_s;
            rd_WB       <= rd_MEM;
            wb_data_WB  <= load_start_s ? format_load(funct3_MEM, ALU_data_MEM[1:0], load_buf_r)
                                        : ALU_data_MEM;
        end
    end

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    // One-cycle misaligned-load flag alongside the MEM/WB register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misalign_WB <= 1'b0;
        end else if (busy_s) begin
            misalign_WB <= 1'b0;
        end else begin
            misalign_WB <= misalign_s;
        end
    end
`endif
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a per-cycle reference model plus literal spot checks.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        memread_MEM, regwrite_MEM, j_MEM, br_MEM, EQ_MEM, LT_MEM, LTU_MEM;
    logic [2:0]  funct3_MEM;
    logic [4:0]  rd_MEM;
    logic [31:0] BTA_MEM, ALU_data_MEM;
    logic        redirect, stall, regwrite_WB;
    logic [31:0] redirect_pc, wb_data_WB;
    logic [4:0]  rd_WB;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    logic        misalign_WB;
`endif
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        run = 1'b0;

    mem_stage_if bus ();

    mem_stage dut (
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        .misalign_WB (misalign_WB),
`endif
        .clk (clk), .reset (reset),
        .memread_MEM (memread_MEM), .regwrite_MEM (regwrite_MEM), .j_MEM (j_MEM),
        .br_MEM (br_MEM), .EQ_MEM (EQ_MEM), .LT_MEM (LT_MEM), .LTU_MEM (LTU_MEM),
        .funct3_MEM (funct3_MEM), .rd_MEM (rd_MEM), .BTA_MEM (BTA_MEM),
        .ALU_data_MEM (ALU_data_MEM), .dmem (bus),
        .redirect (redirect), .redirect_pc (redirect_pc), .stall (stall),
        .regwrite_WB (regwrite_WB), .rd_WB (rd_WB), .wb_data_WB (wb_data_WB)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_phase;   // 0: no load in flight, 1: request outstanding, 2: data returned
    logic [31:0] m_buf, m_wb;
    logic        m_rw, m_mis;
    logic [4:0]  m_rd;

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] w);
        logic [31:0] v;
        case (f3)
            3'd0, 3'd4: begin
                v = (w >> (8 * addr[1:0])) & 32'hFF;
                if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
            end
            3'd1, 3'd5: begin
                v = (w >> (16 * addr[1])) & 32'hFFFF;
                if (f3 == 3'd1 && v >= 32'h8000) v = v - 32'h10000;
            end
            3'd2:    v = w;
            default: v = 32'd0;
        endcase
        return v;
    endfunction

    function automatic logic ref_mis();
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        if (!memread_MEM) return 1'b0;
        if ((funct3_MEM == 3'd1 || funct3_MEM == 3'd5) && ALU_data_MEM[0]) return 1'b1;
        if (funct3_MEM == 3'd2 && ALU_data_MEM[1:0] != 2'd0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic ref_busy();
        if (reset) return 1'b0;
        if (m_phase == 1) return 1'b1;
        return (m_phase == 0) && memread_MEM && !ref_mis();
    endfunction

    function automatic logic ref_redirect();
        logic c;
        case (funct3_MEM)
            3'd0:    c = EQ_MEM;
            3'd1:    c = !EQ_MEM;
            3'd4:    c = LT_MEM;
            3'd5:    c = !LT_MEM;
            3'd6:    c = LTU_MEM;
            3'd7:    c = !LTU_MEM;
            default: c = 1'b0;
        endcase
        return j_MEM || (br_MEM && c);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase <= 0; m_buf <= 32'd0; m_rw <= 1'b0; m_rd <= 5'd0; m_wb <= 32'd0; m_mis <= 1'b0;
        end else begin
            if (ref_busy()) begin
                m_rw  <= 1'b0;
                m_mis <= 1'b0;
            end else begin
                m_rw  <= regwrite_MEM && !ref_mis();
                m_rd  <= rd_MEM;
                m_wb  <= (memread_MEM && !ref_mis()) ? ref_load(funct3_MEM, ALU_data_MEM, m_buf)
                                                     : ALU_data_MEM;
                m_mis <= ref_mis();
            end
            if (m_phase == 1 && bus.dmem_ack) begin
                m_buf   <= bus.dmem_rdata;
                m_phase <= 2;
            end else if (m_phase == 2) begin
                m_phase <= 0;
            end else if (m_phase == 0 && ref_busy()) begin
                m_phase <= 1;
            end
        end
    end

    always @(negedge clk) begin
        if (run) begin
            chk("dmem_req", bus.dmem_req, ref_busy());
            chk("stall", stall, ref_busy());
            chk("dmem_addr", bus.dmem_addr, ALU_data_MEM & 32'hFFFF_FFFC);
            chk("redirect", redirect, ref_redirect());
            chk("redirect_pc", redirect_pc, BTA_MEM);
            chk("regwrite_WB", regwrite_WB, m_rw);
            chk("rd_WB", rd_WB, m_rd);
            chk("wb_data_WB", wb_data_WB, m_wb);
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
            chk("misalign_WB", misalign_WB, m_mis);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle_inputs();
        memread_MEM = 1'b0; regwrite_MEM = 1'b0; j_MEM = 1'b0; br_MEM = 1'b0;
        EQ_MEM = 1'b0; LT_MEM = 1'b0; LTU_MEM = 1'b0; funct3_MEM = 3'd0; rd_MEM = 5'd0;
        BTA_MEM = 32'd0; ALU_data_MEM = 32'd0; bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue a load, ack after 'waits' idle WAIT cycles; returns after the WB edge
    task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                           input logic [31:0] data, input int waits,
                           output int stalls, output logic [31:0] addr_seen);
        stalls = 0;
        memread_MEM = 1'b1; regwrite_MEM = 1'b1; funct3_MEM = f3; ALU_data_MEM = addr; rd_MEM = rd;
        @(negedge clk); addr_seen = bus.dmem_addr; if (stall) stalls++;
        step();
        for (int i = 0; i < waits; i++) begin
            @(negedge clk); if (stall) stalls++;
            step();
        end
        bus.dmem_ack = 1'b1; bus.dmem_rdata = data;
        @(negedge clk); if (stall) stalls++;
        step();
        bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'h0BAD_F00D;
        @(negedge clk); if (stall) stalls++;
        step();
        idle_inputs();
    endtask

    initial begin
        int          st;
        logic [31:0] a;
        idle_inputs();
        #1 reset = 1'b1;
        memread_MEM = 1'b1;
        run = 1'b1;
        step(); step();
        @(negedge clk);
        chk("rst_dmem_req", bus.dmem_req, 1'b0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_regwrite_WB", regwrite_WB, 1'b0);
        chk("rst_wb_data_WB", wb_data_WB, 32'd0);
        step();
        reset = 1'b0;
        idle_inputs();
        bus.dmem_ack = 1'b1;                       // stray ack in IDLE must be ignored
        step();
        bus.dmem_ack = 1'b0;

        // ALU result passes straight through
        regwrite_MEM = 1'b1; rd_MEM = 5'd5; ALU_data_MEM = 32'h1234_5678; funct3_MEM = 3'd2;
        step();
        idle_inputs();
        @(negedge clk);
        chk("alu_wb_data", wb_data_WB, 32'h1234_5678);
        chk("alu_rd", rd_WB, 5'd5);

        // LW 0x100, ack after two empty WAIT cycles
        do_load(3'd2, 32'h100, 5'd7, 32'hDEAD_BEEF, 2, st, a);
        @(negedge clk);
        chk("lw_addr", a, 32'h100);
        chk("lw_stalls", st, 32'd4);
        chk("lw_wb_data", wb_data_WB, 32'hDEAD_BEEF);
        chk("lw_regwrite", regwrite_WB, 1'b1);
        step();

        do_load(3'd0, 32'h103, 5'd8, 32'h8011_2233, 0, st, a);
        @(negedge clk);
        chk("lb_wb_data", wb_data_WB, 32'hFFFF_FF80);
        chk("lb_stalls", st, 32'd2);
        step();
        do_load(3'd4, 32'h103, 5'd9, 32'h8011_2233, 1, st, a);
        @(negedge clk);
        chk("lbu_wb_data", wb_data_WB, 32'h0000_0080);
        step();
        do_load(3'd1, 32'h102, 5'd10, 32'h8001_2233, 0, st, a);
        @(negedge clk);
        chk("lh_wb_data", wb_data_WB, 32'hFFFF_8001);
        step();
        do_load(3'd5, 32'h100, 5'd11, 32'h8001_A233, 3, st, a);
        @(negedge clk);
        chk("lhu_wb_data", wb_data_WB, 32'h0000_A233);
        step();
        do_load(3'd0, 32'h201, 5'd12, 32'h8011_2233, 0, st, a);
        do_load(3'd3, 32'h204, 5'd13, 32'h8011_2233, 0, st, a);
`ifndef MEM_STAGE_MISALIGN_TRAP_EN
        do_load(3'd2, 32'h301, 5'd14, 32'hCAFE_F00D, 0, st, a);
        @(negedge clk);
        chk("lw_unaligned_data", wb_data_WB, 32'hCAFE_F00D);
        step();
        do_load(3'd1, 32'h303, 5'd15, 32'h9876_5432, 0, st, a);
`endif

        // Branch conditions
        br_MEM = 1'b1; funct3_MEM = 3'd5; LT_MEM = 1'b0; BTA_MEM = 32'h2000;
        @(negedge clk);
        chk("bge_taken", redirect, 1'b1);
        chk("bge_target", redirect_pc, 32'h2000);
        step();
        LT_MEM = 1'b1;
        @(negedge clk);
        chk("bge_not_taken", redirect, 1'b0);
        step();
        for (int f = 0; f < 8; f++) begin
            for (int fl = 0; fl < 8; fl++) begin
                funct3_MEM = f[2:0]; {EQ_MEM, LT_MEM, LTU_MEM} = fl[2:0];
                br_MEM = 1'b1; j_MEM = (fl == 5); BTA_MEM = 32'h4000 + 32'(f * 16 + fl);
                step();
            end
        end
        idle_inputs();
        step();

        // Reset pulse while waiting for memory, ack arrives afterwards
        memread_MEM = 1'b1; regwrite_MEM = 1'b1; funct3_MEM = 3'd2; ALU_data_MEM = 32'h500; rd_MEM = 5'd3;
        step(); step();
        reset = 1'b1;
        @(negedge clk);
        chk("rst_wait_dmem_req", bus.dmem_req, 1'b0);
        step();
        reset = 1'b0;
        idle_inputs();
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h1111_1111;
        step();
        bus.dmem_ack = 1'b0;
        @(negedge clk);
        chk("post_rst_dmem_req", bus.dmem_req, 1'b0);
        chk("post_rst_stall", stall, 1'b0);
        chk("post_rst_regwrite", regwrite_WB, 1'b0);
        step();
        do_load(3'd2, 32'h600, 5'd4, 32'h2222_3333, 1, st, a);
        @(negedge clk);
        chk("post_rst_lw_stalls", st, 32'd3);
        chk("post_rst_lw_data", wb_data_WB, 32'h2222_3333);
        step();

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        memread_MEM = 1'b1; regwrite_MEM = 1'b1; funct3_MEM = 3'd2; ALU_data_MEM = 32'h102; rd_MEM = 5'd6;
        @(negedge clk);
        chk("mis_dmem_req", bus.dmem_req, 1'b0);
        chk("mis_stall", stall, 1'b0);
        step();
        idle_inputs();
        @(negedge clk);
        chk("mis_flag", misalign_WB, 1'b1);
        chk("mis_wb_data", wb_data_WB, 32'h102);
        chk("mis_regwrite", regwrite_WB, 1'b0);
        step();
        @(negedge clk);
        chk("mis_flag_clear", misalign_WB, 1'b0);
        step();
        do_load(3'd5, 32'h103, 5'd6, 32'h1234_5678, 0, st, a);
`endif
        step(); step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have port clk  input  1  clock; all flops rise-edge.
REQ-002 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have inputs memread_MEM, regwrite_MEM, j_MEM, br_MEM, EQ_MEM, LT_MEM, LTU_MEM  input  1 each  EX/MEM control and compare flags.
REQ-004 SHALL have ports funct3_MEM  input  3, rd_MEM  input  5, BTA_MEM  input  32, ALU_data_MEM  input  32  (load address, or result/link value).
REQ-005 SHALL have port dmem_req  output  1  data-memory read request.
REQ-006 SHALL have port dmem_addr  output  32  {ALU_data_MEM[31:2],2'b00}.
REQ-007 SHALL have ports dmem_ack  input  1 and dmem_rdata  input  32  read-data handshake.
REQ-008 SHALL have ports redirect  output  1 and redirect_pc  output  32  taken-control-transfer target.
REQ-009 SHALL have port stall  output  1  freezes PC, IF/ID, ID/EX, EX/MEM.
REQ-010 SHALL have ports regwrite_WB  output  1, rd_WB  output  5, wb_data_WB  output  32  MEM/WB register.

Function
REQ-011 SHALL compute redirect combinationally = j_MEM | (br_MEM & cond); redirect_pc = BTA_MEM.
REQ-012 SHALL define cond by funct3_MEM: 000 EQ, 001 !EQ, 100 LT, 101 !LT, 110 LTU, 111 !LTU, 010/011 0.
REQ-013 SHALL run load FSM states IDLE, WAIT, DONE.
REQ-014 IDLE & memread_MEM: dmem_req=1, stall=1, next WAIT; IDLE & !memread_MEM: stay IDLE, stall=0.
REQ-015 WAIT: dmem_req=1, stall=1; on dmem_ack capture dmem_rdata into load buffer, next DONE; else stay WAIT (unbounded).
REQ-016 DONE: dmem_req=0, stall=0, MEM/WB loads formatted buffer, next IDLE; minimum load occupancy 3 cycles.
REQ-017 SHALL ignore dmem_ack outside WAIT.
REQ-018 SHALL format loads by funct3_MEM with a=ALU_data_MEM[1:0]: 000 LB sign-ext byte a, 001 LH sign-ext half a[1], 010 LW, 100 LBU zero-ext, 101 LHU zero-ext; others give 0.
REQ-019 Each non-stall edge: regwrite_WB<=regwrite_MEM, rd_WB<=rd_MEM, wb_data_WB<=formatted load if memread_MEM else ALU_data_MEM.
REQ-020 While stall=1, regwrite_WB<=0 (bubble); rd_WB, wb_data_WB hold.
REQ-021 redirect SHALL never be asserted while stall=1 (branches/jumps carry memread_MEM=0).

Reset
REQ-022 On reset: FSM IDLE, load buffer 0, regwrite_WB 0, rd_WB 0, wb_data_WB 0, dmem_req 0, stall 0.
REQ-023 Reset mid-load (WAIT) SHALL drop dmem_req immediately and discard any later ack.

Configuration
REQ-024 Macro MEM_STAGE_MISALIGN_TRAP_EN SHALL add output misalign_WB  1  registered misaligned-load flag, reset 0.
REQ-025 With macro: LH/LHU with a[0]=1 or LW with a!=0 issues no dmem_req, no stall; next edge regwrite_WB=0, misalign_WB=1, wb_data_WB=ALU_data_MEM; misalign_WB=1 for one cycle only.
REQ-026 Without macro: no misalign_WB port; misaligned loads use REQ-018 lane selection (LW ignores a, LH uses a[1]).

Verification
REQ-027 LW addr 0x100, ack after 2 WAIT cycles, rdata 0xDEADBEEF -> dmem_addr 0x100, stall 4 cycles, wb_data_WB=0xDEADBEEF, regwrite_WB=1.
REQ-028 LB addr 0x103, rdata 0x80112233 -> wb_data_WB=0xFFFFFF80; LBU same -> 0x00000080.
REQ-029 br_MEM=1, funct3=101, LT_MEM=0, BTA 0x2000 -> redirect=1, redirect_pc=0x2000; LT_MEM=1 -> redirect=0.
REQ-030 Reset pulse in WAIT, ack next cycle -> dmem_req 0, FSM IDLE, regwrite_WB stays 0.
REQ-031 With macro, LW addr 0x102 -> no dmem_req, misalign_WB=1 one cycle, wb_data_WB=0x102, regwrite_WB=0.
